ysyx_22050078_stbuf: RTL and testbench

Store buffer between the load/store unit and the data-memory write port. Accepts store requests (address, data, byte mask) from the LSU, queues them in a small in-order FIFO and drains them to memory over a valid/ready handshake, so the LSU never waits on memory for a store. For every load it also reports whether a pending store overlaps the load's doubleword, so the LSU stalls or takes forwarded data instead of reading stale memory.

---
 rtl/ysyx_22050078_stbuf_pkg.sv | 10 +
 rtl/ysyx_22050078_stbuf_if.sv | 40 ++++
 rtl/ysyx_22050078_stbuf_match.sv | 68 ++++++
 rtl/ysyx_22050078_stbuf.sv | 82 ++++++++
 tb/tb_ysyx_22050078_stbuf.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050078_stbuf_pkg.sv
// Shared definitions for the store buffer: CPU width, default depth,
// byte-mask width and doubleword offset width.
package ysyx_22050078_stbuf_pkg;
   localparam int CPU_WIDTH    = 64;
   localparam int STBUF_DEPTH  = 4;
   localparam int STBUF_MASK_W = 8;
   localparam int DW_OFF_W     = 3;

   localparam logic [STBUF_MASK_W-1:0] FULL_MASK = '1;
endpackage

// File: rtl/ysyx_22050078_stbuf_if.sv
// Store buffer bus bundle: LSU store port, LSU load-check port, memory write
// port and status. The buffer uses the slave view, the LSU/memory side the master view.
interface ysyx_22050078_stbuf_if
   import ysyx_22050078_stbuf_pkg::*;
#(
   parameter int DEPTH = STBUF_DEPTH,
   parameter int AW    = CPU_WIDTH,
   parameter int DW    = CPU_WIDTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                    i_st_valid;
   logic                    o_st_ready;
   logic [AW-1:0]           i_st_addr;
   logic [DW-1:0]           i_st_data;
   logic [STBUF_MASK_W-1:0] i_st_wmask;
   logic [AW-1:0]           i_ld_addr;
   logic                    o_ld_conflict;
   logic                    o_ld_hit;
   logic [DW-1:0]           o_ld_data;
   logic                    o_mem_wvalid;
   logic [AW-1:0]           o_mem_waddr;
   logic [DW-1:0]           o_mem_wdata;
   logic [STBUF_MASK_W-1:0] o_mem_wmask;
   logic                    i_mem_wready;
   logic                    o_empty;
   logic [CW-1:0]           o_count;

   modport slave (
      input  i_st_valid, i_st_addr, i_st_data, i_st_wmask, i_ld_addr, i_mem_wready,
      output o_st_ready, o_ld_conflict, o_ld_hit, o_ld_data,
             o_mem_wvalid, o_mem_waddr, o_mem_wdata, o_mem_wmask, o_empty, o_count
   );

   modport master (
      output i_st_valid, i_st_addr, i_st_data, i_st_wmask, i_ld_addr, i_mem_wready,
      input  o_st_ready, o_ld_conflict, o_ld_hit, o_ld_data,
             o_mem_wvalid, o_mem_waddr, o_mem_wdata, o_mem_wmask, o_empty, o_count
   );
endinterface

// File: rtl/ysyx_22050078_stbuf_match.sv
// Load-vs-pending-store doubleword match. Build option STBUF_FWD_EN adds the
// youngest-match priority select and full-doubleword forwarding; without it
// any match simply raises conflict.
module ysyx_22050078_stbuf_match
   import ysyx_22050078_stbuf_pkg::*;
#(
   parameter int DEPTH = STBUF_DEPTH,
   parameter int AW    = CPU_WIDTH,
   parameter int DW    = CPU_WIDTH,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0]           ent_addr  [DEPTH],
   input  logic [DW-1:0]           ent_data  [DEPTH],
   input  logic [STBUF_MASK_W-1:0] ent_wmask [DEPTH],
   input  logic [DEPTH-1:0]        ent_valid,
   input  logic [PW-1:0]           head,
   input  logic [AW-1:0]           ld_addr,
   output logic                    conflict,
   output logic                    hit,
   output logic [DW-1:0]           ld_data
);
   logic [DEPTH-1:0] hit_vec;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      assign hit_vec[g] = ent_valid[g] &&
                          (ent_addr[g][AW-1:DW_OFF_W] == ld_addr[AW-1:DW_OFF_W]);
   end

`ifdef STBUF_FWD_EN
   logic [PW-1:0] young_idx;
   logic [PW-1:0] idx;
   logic          full_dw;

   // walk from head (oldest) towards tail so the last hit seen is the youngest
   always_comb begin
      young_idx = '0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (hit_vec[idx]) young_idx = idx;
      end
   end

   assign full_dw  = (|hit_vec) && (ent_wmask[young_idx] == FULL_MASK);
   assign hit      = full_dw;
   assign ld_data  = full_dw ? ent_data[young_idx] : '0;
   assign conflict = (|hit_vec) && !full_dw;
`else
   assign conflict = |hit_vec;
   assign hit      = 1'b0;
   assign ld_data  = '0;
`endif

   // fold inputs that do not take part in matching into one dead signal
   logic unused_bits;
   always_comb begin
      unused_bits = ^ld_addr[DW_OFF_W-1:0];
      for (int k = 0; k < DEPTH; k++) begin
         unused_bits = unused_bits ^ (^ent_addr[k][DW_OFF_W-1:0]);
`ifndef STBUF_FWD_EN
         unused_bits = unused_bits ^ (^ent_data[k]) ^ (^ent_wmask[k]);
`endif
      end
`ifndef STBUF_FWD_EN
      unused_bits = unused_bits ^ (^head);
`endif
   end
endmodule

// File: rtl/ysyx_22050078_stbuf.sv
// In-order store buffer between LSU and the data-memory write port.
// Optional load forwarding is enabled by defining STBUF_FWD_EN.
module ysyx_22050078_stbuf
   import ysyx_22050078_stbuf_pkg::*;
#(
   parameter int DEPTH = STBUF_DEPTH,
   parameter int AW    = CPU_WIDTH,
   parameter int DW    = CPU_WIDTH
) (
   input logic                    clk,
   input logic                    rst,
   ysyx_22050078_stbuf_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0]           ent_addr  [DEPTH];
   logic [DW-1:0]           ent_data  [DEPTH];
   logic [STBUF_MASK_W-1:0] ent_wmask [DEPTH];
   logic [DEPTH-1:0]        ent_valid;
   logic [PW:0]             head, tail, count;
   logic                    full, empty, push, pop;

   assign count = tail - head;
   assign empty = (head == tail);
   assign full  = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);

   // a zero-mask store handshakes but is dropped
   assign push = bus.i_st_valid && bus.o_st_ready && (bus.i_st_wmask != '0);
   assign pop  = bus.o_mem_wvalid && bus.i_mem_wready;

   assign bus.o_st_ready   = !full && !rst;
   assign bus.o_mem_wvalid = !empty;
   assign bus.o_mem_waddr  = empty ? '0 : ent_addr[head[PW-1:0]];
   assign bus.o_mem_wdata  = empty ? '0 : ent_data[head[PW-1:0]];
   assign bus.o_mem_wmask  = empty ? '0 : ent_wmask[head[PW-1:0]];
   assign bus.o_empty      = empty;
   assign bus.o_count      = count;

   // entry g is live when its distance from head is below the occupancy
   for (genvar g = 0; g < DEPTH; g++) begin : g_valid
      logic [PW-1:0] off;
      assign off          = PW'(g) - head[PW-1:0];
      assign ent_valid[g] = ({1'b0, off} < count);
   end

   // head/tail pointers with wrap bit; reset discards everything pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (push) tail <= tail + (PW+1)'(1);
         if (pop)  head <= head + (PW+1)'(1);
      end
   end

   // entry payload; stale contents are masked by the pointers so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[tail[PW-1:0]]  <= bus.i_st_addr;
         ent_data[tail[PW-1:0]]  <= bus.i_st_data;
         ent_wmask[tail[PW-1:0]] <= bus.i_st_wmask;
      end
   end

   ysyx_22050078_stbuf_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .PW    (PW)
   ) u_match (
      .ent_addr  (ent_addr),
      .ent_data  (ent_data),
      .ent_wmask (ent_wmask),
      .ent_valid (ent_valid),
      .head      (head[PW-1:0]),
      .ld_addr   (bus.i_ld_addr),
      .conflict  (bus.o_ld_conflict),
      .hit       (bus.o_ld_hit),
      .ld_data   (bus.o_ld_data)
   );
endmodule

// File: tb/tb_ysyx_22050078_stbuf.sv
// Directed self-checking bench for the store buffer (DEPTH 4, 64-bit).
module tb_ysyx_22050078_stbuf;
   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   logic [63:0] log_addr [$];
   logic [63:0] log_data [$];
   logic [7:0]  log_mask [$];

   always #5 clk = ~clk;

   ysyx_22050078_stbuf_if #(.DEPTH(4), .AW(64), .DW(64)) bus ();

   ysyx_22050078_stbuf #(.DEPTH(4), .AW(64), .DW(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memory-side record of every accepted write
   always @(posedge clk) begin
      if (!rst && bus.o_mem_wvalid && bus.i_mem_wready) begin
         log_addr.push_back(bus.o_mem_waddr);
         log_data.push_back(bus.o_mem_wdata);
         log_mask.push_back(bus.o_mem_wmask);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_mask.delete();
   endtask

   task automatic drive_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
      bus.i_st_valid = 1'b1;
      bus.i_st_addr  = a;
      bus.i_st_data  = d;
      bus.i_st_wmask = m;
   endtask

   task automatic drain();
      int c;
      c = 0;
      bus.i_st_valid   = 1'b0;
      bus.i_mem_wready = 1'b1;
      while (!bus.o_empty && c < 50) begin
         step();
         c++;
      end
      bus.i_mem_wready = 1'b0;
      n_total++;
      if (bus.o_empty !== 1'b1) $display("FAIL drain_timeout: empty=%b required 1", bus.o_empty);
      else n_pass++;
   endtask

   task automatic test_reset();
      n_total++;
      if (bus.o_st_ready !== 1'b0) $display("FAIL rst_ready_low: got %b required 0", bus.o_st_ready);
      else n_pass++;
      n_total++;
      if (bus.o_mem_wvalid !== 1'b0) $display("FAIL rst_wvalid: got %b required 0", bus.o_mem_wvalid);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.o_st_ready !== 1'b1) $display("FAIL rst_ready_after: got %b required 1", bus.o_st_ready);
      else n_pass++;
      n_total++;
      if (bus.o_empty !== 1'b1) $display("FAIL rst_empty: got %b required 1", bus.o_empty);
      else n_pass++;
      n_total++;
      if (bus.o_count !== 3'd0) $display("FAIL rst_count: got %0d required 0", bus.o_count);
      else n_pass++;
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit, bus.o_mem_waddr} !== 66'd0)
         $display("FAIL rst_outputs: got %h required 0", {bus.o_ld_conflict, bus.o_ld_hit, bus.o_mem_waddr});
      else n_pass++;
      step();
   endtask

   task automatic test_single();
      clear_log();
      bus.i_mem_wready = 1'b0;
      bus.i_ld_addr    = 64'h8000_0010;
      drive_store(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
      @(negedge clk);
      n_total++;
      if (bus.o_mem_wvalid !== 1'b0) $display("FAIL single_no_bypass: wvalid=%b required 0", bus.o_mem_wvalid);
      else n_pass++;
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit} !== 2'b00)
         $display("FAIL single_same_cycle_invisible: conflict/hit=%b required 00", {bus.o_ld_conflict, bus.o_ld_hit});
      else n_pass++;
      step();
      bus.i_st_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.o_mem_wvalid, bus.o_mem_waddr, bus.o_mem_wdata, bus.o_mem_wmask} !==
          {1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF})
         $display("FAIL single_head: got %b %h %h %h required 1 8000_0010 1122334455667788 ff",
                  bus.o_mem_wvalid, bus.o_mem_waddr, bus.o_mem_wdata, bus.o_mem_wmask);
      else n_pass++;
      n_total++;
      if (bus.o_count !== 3'd1) $display("FAIL single_count: got %0d required 1", bus.o_count);
      else n_pass++;
`ifdef STBUF_FWD_EN
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data} !== {2'b01, 64'h1122_3344_5566_7788})
         $display("FAIL single_fwd: got %b %b %h required 0 1 1122334455667788",
                  bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data);
      else n_pass++;
`else
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data} !== {2'b10, 64'd0})
         $display("FAIL single_conflict: got %b %b %h required 1 0 0",
                  bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data);
      else n_pass++;
`endif
      step();
      bus.i_mem_wready = 1'b1;
      @(negedge clk);
      n_total++;
      if ({bus.o_mem_wvalid, bus.o_mem_wdata} !== {1'b1, 64'h1122_3344_5566_7788})
         $display("FAIL single_held: got %b %h required 1 1122334455667788", bus.o_mem_wvalid, bus.o_mem_wdata);
      else n_pass++;
      n_total++;
      if ((bus.o_ld_conflict | bus.o_ld_hit) !== 1'b1)
         $display("FAIL single_pop_cycle_match: got %b required 1", bus.o_ld_conflict | bus.o_ld_hit);
      else n_pass++;
      step();
      bus.i_mem_wready = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.o_empty, bus.o_count} !== {1'b1, 3'd0})
         $display("FAIL single_empty: empty=%b count=%0d required 1 0", bus.o_empty, bus.o_count);
      else n_pass++;
      n_total++;
      if (log_data.size() != 1 || log_data[0] !== 64'h1122_3344_5566_7788 || log_addr[0] !== 64'h8000_0010)
         $display("FAIL single_mem_write: got %0d writes required 1 of 1122334455667788", log_data.size());
      else n_pass++;
      step();
   endtask

   task automatic test_full();
      clear_log();
      bus.i_mem_wready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_store(64'h100 + 64'(8 * k), 64'hF0 + 64'(k), 8'hFF);
         step();
      end
      drive_store(64'h120, 64'hF4, 8'hFF);
      @(negedge clk);
      n_total++;
      if ({bus.o_count, bus.o_st_ready} !== {3'd4, 1'b0})
         $display("FAIL full_after4: count=%0d ready=%b required 4 0", bus.o_count, bus.o_st_ready);
      else n_pass++;
      step();
      @(negedge clk);
      n_total++;
      if (bus.o_count !== 3'd4) $display("FAIL full_hold: count=%0d required 4", bus.o_count);
      else n_pass++;
      step();
      bus.i_mem_wready = 1'b1;
      @(negedge clk);
      n_total++;
      if (bus.o_st_ready !== 1'b0) $display("FAIL full_no_bypass: ready=%b required 0", bus.o_st_ready);
      else n_pass++;
      step();
      @(negedge clk);
      n_total++;
      if ({bus.o_count, bus.o_st_ready} !== {3'd3, 1'b1})
         $display("FAIL full_refused: count=%0d ready=%b required 3 1", bus.o_count, bus.o_st_ready);
      else n_pass++;
      step();
      bus.i_st_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.o_count !== 3'd3) $display("FAIL full_push_pop: count=%0d required 3", bus.o_count);
      else n_pass++;
      step();
      drain();
      n_total++;
      if (log_data.size() != 5) $display("FAIL full_log_size: got %0d required 5", log_data.size());
      else n_pass++;
      for (int k = 0; k < log_data.size() && k < 5; k++) begin
         n_total++;
         if (log_data[k] !== 64'hF0 + 64'(k) || log_addr[k] !== 64'h100 + 64'(8 * k))
            $display("FAIL full_order[%0d]: got %h@%h required %h@%h",
                     k, log_data[k], log_addr[k], 64'hF0 + 64'(k), 64'h100 + 64'(8 * k));
         else n_pass++;
      end
   endtask

   task automatic test_stream();
      int idx, cyc;
      logic acc;
      clear_log();
      idx = 0;
      cyc = 0;
      while (idx < 20 && cyc < 400) begin
         drive_store(64'h2000 + 64'(8 * idx), 64'hD000 + 64'(idx), 8'hFF >> (idx % 4));
         bus.i_mem_wready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = bus.o_st_ready;
         step();
         if (acc) idx++;
         cyc++;
      end
      n_total++;
      if (idx != 20) $display("FAIL stream_pushed: got %0d required 20", idx);
      else n_pass++;
      drain();
      n_total++;
      if (log_data.size() != 20) $display("FAIL stream_log_size: got %0d required 20", log_data.size());
      else n_pass++;
      for (int k = 0; k < log_data.size() && k < 20; k++) begin
         n_total++;
         if (log_data[k] !== 64'hD000 + 64'(k) || log_addr[k] !== 64'h2000 + 64'(8 * k) ||
             log_mask[k] !== (8'hFF >> (k % 4)))
            $display("FAIL stream_order[%0d]: got %h@%h/%h required %h@%h/%h", k, log_data[k], log_addr[k],
                     log_mask[k], 64'hD000 + 64'(k), 64'h2000 + 64'(8 * k), 8'hFF >> (k % 4));
         else n_pass++;
      end
   endtask

   task automatic test_conflict();
      clear_log();
      bus.i_mem_wready = 1'b0;
      drive_store(64'h8000_0008, 64'h5555_6666_7777_8888, 8'h0F);
      step();
      bus.i_st_valid = 1'b0;
      bus.i_ld_addr  = 64'h8000_000C;
      @(negedge clk);
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit} !== 2'b10)
         $display("FAIL conflict_same_dw: conflict/hit=%b required 10", {bus.o_ld_conflict, bus.o_ld_hit});
      else n_pass++;
      bus.i_ld_addr = 64'h8000_0010;
      #1;
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit} !== 2'b00)
         $display("FAIL conflict_other_dw: conflict/hit=%b required 00", {bus.o_ld_conflict, bus.o_ld_hit});
      else n_pass++;
      step();
      drive_store(64'h8000_0010, 64'h1234, 8'h00);
      @(negedge clk);
      n_total++;
      if (bus.o_st_ready !== 1'b1) $display("FAIL zero_mask_ready: got %b required 1", bus.o_st_ready);
      else n_pass++;
      step();
      bus.i_st_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.o_count, bus.o_ld_conflict} !== {3'd1, 1'b0})
         $display("FAIL zero_mask_dropped: count=%0d conflict=%b required 1 0", bus.o_count, bus.o_ld_conflict);
      else n_pass++;
      step();
      drain();
      n_total++;
      if (log_data.size() != 1 || log_mask[0] !== 8'h0F)
         $display("FAIL conflict_log: got %0d writes required 1 with mask 0f", log_data.size());
      else n_pass++;
   endtask

   task automatic test_forward();
      clear_log();
      bus.i_mem_wready = 1'b0;
      drive_store(64'h8000_0020, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      step();
      drive_store(64'h8000_0020, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
      step();
      bus.i_st_valid = 1'b0;
      bus.i_ld_addr  = 64'h8000_0020;
      @(negedge clk);
`ifdef STBUF_FWD_EN
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data} !== {2'b01, 64'hBBBB_BBBB_BBBB_BBBB})
         $display("FAIL fwd_youngest: got %b %b %h required 0 1 bbbbbbbbbbbbbbbb",
                  bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data);
      else n_pass++;
`else
      n_total++;
      if ({bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data} !== {2'b10, 64'd0})
         $display("FAIL nofwd_conflict: got %b %b %h required 1 0 0",
                  bus.o_ld_conflict, bus.o_ld_hit, bus.o_ld_data);
      else n_pass++;
`endif
      step();
      drain();
      n_total++;
      if (log_data.size() != 2 || log_data[0] !== 64'hAAAA_AAAA_AAAA_AAAA || log_data[1] !== 64'hBBBB_BBBB_BBBB_BBBB)
         $display("FAIL fwd_log: got %0d writes required AA then BB", log_data.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      clear_log();
      bus.i_mem_wready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_store(64'h3000 + 64'(8 * k), 64'hC0 + 64'(k), 8'hFF);
         step();
      end
      bus.i_st_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if ({bus.o_count, bus.o_mem_wvalid} !== {3'd3, 1'b1})
         $display("FAIL mid_pending: count=%0d wvalid=%b required 3 1", bus.o_count, bus.o_mem_wvalid);
      else n_pass++;
      step();
      rst = 1'b1;
      #1;
      n_total++;
      if ({bus.o_mem_wvalid, bus.o_count, bus.o_empty, bus.o_st_ready} !== {1'b0, 3'd0, 1'b1, 1'b0})
         $display("FAIL mid_async: wvalid=%b count=%0d empty=%b ready=%b required 0 0 1 0",
                  bus.o_mem_wvalid, bus.o_count, bus.o_empty, bus.o_st_ready);
      else n_pass++;
      bus.i_mem_wready = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (3) step();
      bus.i_mem_wready = 1'b0;
      n_total++;
      if (log_data.size() != 0) $display("FAIL mid_no_writes: got %0d writes required 0", log_data.size());
      else n_pass++;
      n_total++;
      if ({bus.o_count, bus.o_empty, bus.o_st_ready} !== {3'd0, 1'b1, 1'b1})
         $display("FAIL mid_after: count=%0d empty=%b ready=%b required 0 1 1",
                  bus.o_count, bus.o_empty, bus.o_st_ready);
      else n_pass++;
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_st_valid   = 1'b0;
      bus.i_st_addr    = '0;
      bus.i_st_data    = '0;
      bus.i_st_wmask   = '0;
      bus.i_ld_addr    = '0;
      bus.i_mem_wready = 1'b0;
      repeat (2) step();
      test_reset();
      test_single();
      test_full();
      test_stream();
      test_conflict();
      test_forward();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
